// File: rtl/obi_mem_responder_pkg.sv
// Shared types for the OBI memory responder: bus bundles, response
// pipeline entry and grant FSM encoding.
package obi_mem_responder_pkg;

    localparam logic [31:0] ErrRdataDefault = 32'hBADCAB1E;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        oor;
    } resp_pipe_t;

    typedef enum logic [0:0] {
        GntIdle = 1'b0,
        GntWait = 1'b1
    } gnt_state_e;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI request/response channel between an initiator and the responder.
interface obi_mem_responder_if;
    import obi_mem_responder_pkg::*;

    obi_req_t  obi_req;
    obi_resp_t obi_resp;

    modport master (
        output obi_req,
        input  obi_resp
    );

    modport slave (
        input  obi_req,
        output obi_resp
    );

endinterface

// File: rtl/obi_resp_delay_line.sv
// Fixed-depth response shift register; stage 0 is loaded every cycle,
// the last stage is the bus response.
module obi_resp_delay_line
    import obi_mem_responder_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  resp_pipe_t in_i,
    output resp_pipe_t out_o
);

    resp_pipe_t stage_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI target backed by a flop memory with configurable grant wait states
// and fixed response latency; oor_o pulses alongside an out-of-range response.
module obi_mem_responder
    import obi_mem_responder_pkg::*;
#(
    parameter int unsigned NumWords    = 64,
    parameter int unsigned WaitStates  = 0,
    parameter int unsigned ReadLatency = 1,
    parameter logic [31:0] ErrRdata    = ErrRdataDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    obi_mem_responder_if.slave   obi_io,
    output logic                 oor_o
);

    localparam int unsigned AddrW = $clog2(NumWords);
    localparam logic [0:0] StIdle = GntIdle;
    localparam logic [0:0] StWait = GntWait;

    obi_req_t   req;
    obi_resp_t  resp;
    resp_pipe_t pipe_in;
    resp_pipe_t pipe_out;

    logic [0:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             gnt;
    logic             accept;
    logic             in_range;
    logic [AddrW-1:0] idx;
    logic [31:0]      mem_q [NumWords];
    logic             unused_addr_lsb;

    assign req             = obi_io.obi_req;
    assign unused_addr_lsb = ^req.addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (WaitStates == 0) begin
            gnt = req.req;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req.req) begin
                        state_d = StWait;
                        cnt_d   = 3'd1;
                    end
                end
                StWait: begin
                    gnt = (cnt_q == 3'(WaitStates));
                    // A dropped request abandons the wait without an access
                    if (gnt || !req.req) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign accept   = req.req & gnt;
    assign in_range = req.addr[31:2] < 30'(NumWords);
    assign idx      = req.addr[AddrW+1:2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
        end else if (accept && req.we && in_range) begin
            mem_q[idx] <= be_merge(mem_q[idx], req.wdata, req.be);
        end
    end

    always_comb begin
        pipe_in = '0;
        if (accept) begin
            pipe_in.valid = 1'b1;
            pipe_in.oor   = !in_range;
            if (!req.we) pipe_in.rdata = in_range ? mem_q[idx] : ErrRdata;
        end
    end

    obi_resp_delay_line #(
        .Depth (ReadLatency)
    ) u_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (pipe_in),
        .out_o (pipe_out)
    );

    always_comb begin
        resp        = '0;
        resp.gnt    = gnt;
        resp.rvalid = pipe_out.valid;
        resp.rdata  = pipe_out.valid ? pipe_out.rdata : '0;
    end

    assign obi_io.obi_resp = resp;
    assign oor_o           = pipe_out.valid & pipe_out.oor;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Drives one shared request bus into three responder configurations and
// checks each against a per-cycle transaction-level model.
module tb_obi_mem_responder;
    import obi_mem_responder_pkg::*;

    localparam int K = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obi_req_t  req_s;
    obi_resp_t rsp [K];
    logic      oor [K];

    obi_mem_responder_if bus0 ();
    obi_mem_responder_if bus1 ();
    obi_mem_responder_if bus2 ();

    assign bus0.obi_req = req_s;
    assign bus1.obi_req = req_s;
    assign bus2.obi_req = req_s;
    assign rsp[0] = bus0.obi_resp;
    assign rsp[1] = bus1.obi_resp;
    assign rsp[2] = bus2.obi_resp;

    obi_mem_responder #(
        .NumWords(64), .WaitStates(0), .ReadLatency(1)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .obi_io(bus0), .oor_o(oor[0])
    );

    obi_mem_responder #(
        .NumWords(64), .WaitStates(3), .ReadLatency(3)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .obi_io(bus1), .oor_o(oor[1])
    );

    obi_mem_responder #(
        .NumWords(40), .WaitStates(1), .ReadLatency(4)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .obi_io(bus2), .oor_o(oor[2])
    );

    int nw [K];
    int wt [K];
    int lt [K];

    logic [31:0] mm [K][64];
    bit          ong [K];
    int          st [K];
    bit          ev [K][8];
    logic [31:0] ed [K][8];
    bit          eo [K][8];

    int cyc;
    int checks;
    int failures;

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h",
                   tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_cycle(input int k);
        int   slot;
        int   ns;
        int   w;
        logic eg;
        logic acc;
        bit   oorx;
        slot = cyc % 8;
        if (rst) begin
            chk("rst_gnt", k, 32'(rsp[k].gnt), 32'd0);
            chk("rst_rvalid", k, 32'(rsp[k].rvalid), 32'd0);
            chk("rst_rdata", k, rsp[k].rdata, 32'd0);
            chk("rst_oor", k, 32'(oor[k]), 32'd0);
            for (int i = 0; i < 64; i++) mm[k][i] = '0;
            for (int s = 0; s < 8; s++) begin
                ev[k][s] = 1'b0;
                ed[k][s] = '0;
                eo[k][s] = 1'b0;
            end
            ong[k] = 1'b0;
            return;
        end
        chk("rvalid", k, 32'(rsp[k].rvalid), 32'(ev[k][slot]));
        chk("rdata", k, rsp[k].rdata, ed[k][slot]);
        chk("oor", k, 32'(oor[k]), 32'(eo[k][slot]));
        ev[k][slot] = 1'b0;
        ed[k][slot] = '0;
        eo[k][slot] = 1'b0;

        // grant comes on the W-th cycle after a request attempt begins
        if (wt[k] == 0) begin
            eg = req_s.req;
        end else if (!ong[k]) begin
            eg = 1'b0;
            if (req_s.req) begin
                ong[k] = 1'b1;
                st[k]  = cyc;
            end
        end else begin
            eg = ((cyc - st[k]) == wt[k]);
            if (eg || !req_s.req) ong[k] = 1'b0;
        end
        chk("gnt", k, 32'(rsp[k].gnt), 32'(eg));

        acc = req_s.req && eg;
        ns  = (cyc + lt[k]) % 8;
        ev[k][ns] = acc;
        ed[k][ns] = '0;
        eo[k][ns] = 1'b0;
        if (acc) begin
            oorx = (req_s.addr[31:2] >= 30'(nw[k]));
            eo[k][ns] = oorx;
            w = int'(req_s.addr[7:2]);
            if (!req_s.we) begin
                ed[k][ns] = oorx ? 32'hBADCAB1E : mm[k][w];
            end else if (!oorx) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_s.be[b]) mm[k][w][8*b +: 8] = req_s.wdata[8*b +: 8];
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < K; k++) model_cycle(k);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req_s.req   = 1'b0;
        req_s.we    = 1'bx;
        req_s.be    = 4'bxxxx;
        req_s.wdata = 'x;
        repeat (n) tick();
    endtask

    // Held for 4 cycles so even the 3-wait-state responder accepts it
    task automatic xfer(input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int n);
        req_s.req   = 1'b1;
        req_s.we    = we;
        req_s.be    = be;
        req_s.addr  = addr;
        req_s.wdata = wdata;
        repeat (n) tick();
    endtask

    initial begin
        nw[0] = 64; wt[0] = 0; lt[0] = 1;
        nw[1] = 64; wt[1] = 3; lt[1] = 3;
        nw[2] = 40; wt[2] = 1; lt[2] = 4;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        req_s    = '0;

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(10);

        for (int i = 0; i < 64; i++) xfer(1'b0, 4'h0, 32'(i * 4), '0, 4);
        idle(5);

        xfer(1'b1, 4'hF, 32'h10, 32'hA5A5_1234, 4);
        xfer(1'b0, 4'h0, 32'h10, '0, 4);
        idle(5);

        xfer(1'b1, 4'hF, 32'h20, 32'h1122_3344, 4);
        xfer(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 4);
        xfer(1'b0, 4'h0, 32'h23, '0, 4);
        xfer(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 4);
        xfer(1'b0, 4'h0, 32'h20, '0, 4);
        idle(5);

        xfer(1'b0, 4'h0, 32'h10, '0, 4);
        xfer(1'b0, 4'h0, 32'h20, '0, 4);
        xfer(1'b0, 4'h0, 32'h00, '0, 4);
        xfer(1'b0, 4'h0, 32'h9C, '0, 4);
        idle(5);

        xfer(1'b0, 4'h0, 32'h100, '0, 4);
        xfer(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 4);
        xfer(1'b1, 4'hF, 32'hA0, 32'hCAFE_F00D, 4);
        xfer(1'b0, 4'h0, 32'h00, '0, 4);
        xfer(1'b0, 4'h0, 32'hFFFF_FFFC, '0, 4);
        idle(5);

        xfer(1'b0, 4'h0, 32'h10, '0, 2);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);
        xfer(1'b0, 4'h0, 32'h10, '0, 4);
        xfer(1'b0, 4'h0, 32'h20, '0, 4);
        idle(5);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                req_s.req   = 1'b1;
                req_s.we    = 1'($urandom_range(0, 1));
                req_s.be    = 4'($urandom_range(0, 15));
                req_s.wdata = $urandom;
                if ($urandom_range(0, 15) == 0) req_s.addr = $urandom;
                else req_s.addr = 32'($urandom_range(0, 70) * 4 + $urandom_range(0, 3));
                tick();
            end else begin
                idle(1);
            end
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- OBI responder (target) for the `obi_req_t` / `obi_resp_t` channel used by the CPU instruction and data ports.
- Serves word-addressed reads and byte-enabled writes from an internal flop-based memory.
- Grant timing and read latency are configurable, so the bench and SoC can exercise core fetch/LSU stalls.
- Sits behind the bus crossbar as a scratch/boot-ROM-style target, or is tied directly to a core port in unit tests.

Parameters:
- NumWords, 64, number of 32-bit words stored; must be ≥2. AddrW = $clog2(NumWords).
- WaitStates, 0, cycles `req` must be held high before `gnt` is given (0..7).
- ReadLatency, 1, cycles from accept cycle to `rvalid` (1..4); applies to reads and writes.
- ErrRdata, 32'hBADCAB1E, `rdata` returned for out-of-range reads.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- obi_req_i  input  obi_req_t  initiator request: `req`, `we`, `be[3:0]`, `addr[31:0]`, `wdata[31:0]`.
- obi_resp_o  output  obi_resp_t  response: `gnt`, `rvalid`, `rdata[31:0]`.
- oor_o  output  1  one-cycle pulse when an out-of-range access is accepted.

Behaviour:
- Interface decision: one clock `clk_i`; reset `rst_i` is asynchronous and active-high.
- Reset values:
  - `gnt`=0, `rvalid`=0, `rdata`=0, `oor_o`=0.
  - Memory cleared to 0, latency pipeline cleared, wait counter 0.
- Accept condition: accept = `req` & `gnt`.
- Grant FSM, states IDLE and WAIT:
  - WaitStates=0: `gnt` = `req` combinationally, FSM stays in IDLE.
  - WaitStates>0, IDLE: `req`=1 → WAIT, cnt=1, `gnt`=0.
  - WAIT: `gnt`=(cnt==WaitStates). If `gnt`, return to IDLE and clear cnt; otherwise cnt++.
  - WAIT with `req`=0 (protocol violation): return to IDLE, cnt=0, no access performed.
  - Back-to-back requests each pay the full WaitStates.
- Addressing:
  - Word index = `addr[AddrW+1:2]`; `addr[1:0]` is ignored.
  - In range iff `addr[31:2]` < NumWords; otherwise the access is out of range (oor).
- Write (accept, `we`=1, in range):
  - `mem[idx]` byte lanes with `be[i]`=1 take `wdata[8i+7:8i]` at the accept clock edge.
  - `be`=0 changes nothing but is still responded to.
- Read (accept, `we`=0):
  - Data sampled from `mem[idx]` at the accept edge; ErrRdata if oor.
  - Data written by any earlier accepted transaction is visible.
- Out-of-range write: memory unchanged, `oor_o` pulses, `rvalid` is still returned.
- Response timing:
  - `rvalid`=1 exactly ReadLatency cycles after the accept cycle.
  - Responses are strictly in order; one `rvalid` per accept.
  - Write response `rdata`=0.
  - With ReadLatency=L, up to L transactions may be outstanding. Accepts in consecutive cycles give `rvalid` in consecutive cycles.
  - No `rready`: the responder never stalls responses.
  - `rdata` = 0 whenever `rvalid`=0.
- Reset mid-operation: pipeline flushed; no `rvalid` for pre-reset accepts; memory cleared; FSM to IDLE.
- Simultaneous events: a read and a write to the same word cannot both be accepted in one cycle (single port). Read-after-write in the next cycle returns new data.
- Unknown (X) `be`/`we` on a non-`req` cycle is ignored.

Decomposition:
- Shared package: `obi_mem_responder_pkg`
  - `ErrRdataDefault`.
  - `resp_pipe_t` struct {valid, rdata[31:0], oor}.
  - Grant FSM enum `gnt_state_e` {IDLE, WAIT}.
- Sub-module: `obi_resp_delay_line`
  - Parameterized shift register of `resp_pipe_t`, depth ReadLatency, reset-flushed.
  - Top drives stage 0 on accept.
- Memory array, grant FSM and address decode live in the top.

Test Plan:
- Reset then idle: `req`=0 for 10 cycles → `gnt`=0, `rvalid`=0, `rdata`=0 throughout; all words read back 0.
- W=0, L=1: write addr 0x10 wdata 0xA5A5_1234 `be`=4'b1111, then read 0x10 in next cycle → `gnt` same cycle as `req`; read `rvalid` 1 cycle after accept, `rdata`=0xA5A5_1234.
- Byte enables: word 0x20 = 0x11223344, write `be`=4'b0101 wdata 0xAABBCCDD → read returns 0x11BB33DD; `be`=0 write leaves it and still yields `rvalid`.
- W=3, L=3: four back-to-back reads → each `gnt` 3 cycles after its `req` rise; `rvalid` 3 cycles after each accept, in order, with correct data.
- Out of range, NumWords=64: read addr 0x100 → `rdata`=0xBADCAB1E, `oor_o` pulse; write 0x100 → no word changes, `rvalid` with `rdata`=0.
- Reset mid-flight, L=4: two reads accepted, `rst_i` pulsed 1 cycle later → no `rvalid` ever appears for them; memory reads back 0.
